// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the dual-core coherence bus controller.
package coherence_bus_ctrl_pkg;

  localparam int NCPU_DEFAULT     = 2;
  localparam int SNOOP_TO_DEFAULT = 15;
  // Snoop cycles during which the peer's cctrans is not yet meaningful.
  localparam int SNOOP_IGNORE     = 2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    IFETCH,
    SNOOP,
    C2C,
    MEMRD
  } bus_state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    REQ_WB,
    REQ_DREAD,
    REQ_IREAD
  } req_class_t;

  // Two-core round-robin pick: on a tie the core that was not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_arbiter.sv
// Request classifier and two-core round-robin arbiter with last-grant memory.
module bus_rr_arbiter
  import coherence_bus_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] i_iren,
  input  logic [1:0] i_dren,
  input  logic [1:0] i_dwen,
  input  logic       i_take,
  output logic       o_valid,
  output logic       o_grant,
  output req_class_t o_class
);

  logic [1:0] w_wb_req;
  logic [1:0] w_cls_req;
  logic       r_last_grant;

  // Pick the highest-priority request class, then the core inside that class.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    o_valid   = 1'b1;
    o_class   = REQ_WB;
    w_wb_req  = i_dwen & ~i_dren;
    w_cls_req = w_wb_req;
    if (|w_wb_req) begin
      o_class   = REQ_WB;
      w_cls_req = w_wb_req;
    end else if (|i_dren) begin
      o_class   = REQ_DREAD;
      w_cls_req = i_dren;
    end else if (|i_iren) begin
      o_class   = REQ_IREAD;
      w_cls_req = i_iren;
    end else begin
      o_valid   = 1'b0;
      w_cls_req = 2'b00;
    end
    o_grant = rr_pick(w_cls_req, r_last_grant);
  end

  // Remember the most recent winner so ties alternate.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (RST) begin
      r_last_grant <= 1'b0;
    end else if (i_take && o_valid) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Bus controller: arbitrates icache/dcache traffic of two cores onto one RAM
// port and runs the MESI snoop / cache-to-cache transfer handshake.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int NCPU     = NCPU_DEFAULT,    // only 2 is supported
  parameter int SNOOP_TO = SNOOP_TO_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCPU-1:0]       iREN,
  input  logic [NCPU-1:0][31:0] iaddr,
  output logic [NCPU-1:0]       iwait,
  output logic [NCPU-1:0][31:0] iload,
  input  logic [NCPU-1:0]       dREN,
  input  logic [NCPU-1:0]       dWEN,
  input  logic [NCPU-1:0][31:0] daddr,
  input  logic [NCPU-1:0][31:0] dstore,
  input  logic [NCPU-1:0]       ccwrite,
  input  logic [NCPU-1:0]       cctrans,
  output logic [NCPU-1:0]       dwait,
  output logic [NCPU-1:0][31:0] dload,
  output logic [NCPU-1:0]       ccwait,
  output logic [NCPU-1:0]       ccinv,
  output logic [NCPU-1:0][31:0] ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  localparam int CNT_W = $clog2(SNOOP_TO + 1);

  bus_state_t       r_state;
  logic             r_grant;
  logic             r_word;
  logic [CNT_W-1:0] r_snoop_cnt;

  logic             w_other;
  logic             w_ram_access;
  logic             w_c2c_done;
  logic             w_d_drop;
  logic             w_take;
  logic             w_arb_valid;
  logic             w_arb_grant;
  req_class_t       w_arb_class;
  logic [CNT_W-1:0] w_snoop_inc;

  assign w_other      = ~r_grant;
  // ERROR is deliberately not special-cased: anything but ACCESS means retry.
  assign w_ram_access = (ramstate == RAM_ACCESS);
  assign w_d_drop     = ~dREN[r_grant] & ~dWEN[r_grant];
  assign w_take       = (r_state == IDLE);
  assign w_snoop_inc  = r_snoop_cnt + CNT_W'(1);

  bus_rr_arbiter u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .i_iren  (iREN),
    .i_dren  (dREN),
    .i_dwen  (dWEN),
    .i_take  (w_take),
    .o_valid (w_arb_valid),
    .o_grant (w_arb_grant),
    .o_class (w_arb_class)
  );

  // Drive core, snoop and RAM handshakes from the current state and grant.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    w_c2c_done  = 1'b0;
    case (r_state)
      WB: begin
        // Gate the strobe with dWEN so the tail cycle after the last word
        // does not start a stray RAM write.
        ramWEN   = dWEN[r_grant];
        ramaddr  = daddr[r_grant];
        ramstore = dstore[r_grant];
        if (w_ram_access) dwait[r_grant] = 1'b0;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_grant];
        if (w_ram_access) begin
          iload[r_grant] = ramload;
          iwait[r_grant] = 1'b0;
        end
      end
      SNOOP: begin
        ccwait[w_other]      = 1'b1;
        ccsnoopaddr[w_other] = daddr[r_grant];
        ccinv[w_other]       = ccwrite[r_grant];
      end
      C2C: begin
        ccwait[w_other]      = 1'b1;
        ccsnoopaddr[w_other] = daddr[r_grant];
        ccinv[w_other]       = ccwrite[r_grant];
        dload[r_grant]       = dstore[w_other];
        if (cctrans[w_other]) begin
          // Modified line: the supplied word is also written back to RAM.
          ramWEN     = 1'b1;
          ramaddr    = daddr[r_grant];
          ramstore   = dstore[w_other];
          w_c2c_done = w_ram_access;
        end else begin
          w_c2c_done = 1'b1;
        end
        if (w_c2c_done) begin
          dwait[r_grant] = 1'b0;
          dwait[w_other] = 1'b0;
        end
      end
      MEMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_grant];
        if (w_ram_access) begin
          dload[r_grant] = ramload;
          dwait[r_grant] = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Bus FSM: grant in IDLE, then sequence words and snoop outcomes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_grant     <= 1'b0;
      r_word      <= 1'b0;
      r_snoop_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_grant     <= w_arb_grant;
            r_word      <= 1'b0;
            r_snoop_cnt <= '0;
            case (w_arb_class)
              REQ_WB:    r_state <= WB;
              REQ_DREAD: r_state <= SNOOP;
              default:   r_state <= IFETCH;
            endcase
          end
        end
        WB: begin
          // Writer holds dWEN across both words; dropping it ends the burst.
          if (~dWEN[r_grant]) r_state <= IDLE;
        end
        IFETCH: begin
          if (w_ram_access) r_state <= IDLE;
        end
        SNOOP: begin
          if (w_d_drop) begin
            r_state <= IDLE;
          end else begin
            r_snoop_cnt <= w_snoop_inc;
            if (dWEN[w_other]) begin
              r_state <= C2C;
            end else if (~cctrans[w_other] && (r_snoop_cnt >= CNT_W'(SNOOP_IGNORE))) begin
              r_state <= MEMRD;
            end else if (w_snoop_inc == CNT_W'(SNOOP_TO)) begin
              r_state <= MEMRD;
            end
          end
        end
        C2C: begin
          if (w_d_drop) begin
            r_state <= IDLE;
            r_word  <= 1'b0;
          end else if (w_c2c_done) begin
            if (r_word) begin
              r_state <= IDLE;
              r_word  <= 1'b0;
            end else begin
              r_word <= 1'b1;
            end
          end
        end
        MEMRD: begin
          if (w_d_drop) begin
            r_state <= IDLE;
            r_word  <= 1'b0;
          end else if (w_ram_access) begin
            if (r_word) begin
              r_state <= IDLE;
              r_word  <= 1'b0;
            end else begin
              r_word <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: drivers push expected data/RAM
// traffic into queues, a negedge monitor pops and compares on every handshake.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  localparam int RAM_LAT  = 2;
  localparam int SNOOP_TO = 15;
  localparam int BUDGET   = 200;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        iREN, dREN, dWEN, ccwrite, cctrans;
  logic [1:0][31:0]  iaddr, daddr, dstore;
  logic [1:0]        iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0]  iload, dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] exp_d0[$];
  logic [31:0] exp_d1[$];
  logic [31:0] exp_i0[$];
  logic [31:0] exp_i1[$];
  logic [31:0] exp_r[$];
  wr_t         exp_w[$];

  logic [31:0] mem [0:1023];
  int          ram_cnt = 0;
  int          ram_wr_count = 0;
  logic        ram_req;

  coherence_bus_ctrl #(.NCPU(2), .SNOOP_TO(SNOOP_TO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      16:      return 32'h8C01_0000;  // 0x040
      128:     return 32'h1111_2222;  // 0x200
      129:     return 32'h3333_4444;  // 0x204
      192:     return 32'h3000_0001;  // 0x300
      193:     return 32'h3000_0002;  // 0x304
      256:     return 32'h4000_0001;  // 0x400
      257:     return 32'h4000_0002;  // 0x404
      320:     return 32'h5000_0001;  // 0x500
      321:     return 32'h5000_0002;  // 0x504
      default: return 32'h0BAD_0000 | 32'(idx);
    endcase
  endfunction

  // RAM model: RAM_LAT busy cycles, then one ACCESS cycle per request.
  assign ram_req = ramREN | ramWEN;
  always_comb begin
    ramstate = 2'd0;
    if (ram_req) ramstate = (ram_cnt >= RAM_LAT) ? 2'd2 : 2'd1;
    ramload = mem[ramaddr[11:2]];
  end

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      ram_cnt <= 0;
    end else if (ram_req && ramstate == 2'd2) begin
      if (ramWEN) begin
        mem[ramaddr[11:2]] <= ramstore;
        ram_wr_count       <= ram_wr_count + 1;
      end
      ram_cnt <= 0;
    end else if (ram_req) begin
      ram_cnt <= ram_cnt + 1;
    end else begin
      ram_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pop the scoreboard whenever the DUT completes a handshake.
  always @(negedge CLK) begin
    if (!RST) begin
      check("ram_ren_wen_exclusive", 32'(ramREN & ramWEN), 32'd0);
      if (!dwait[0] && dREN[0]) begin
        if (exp_d0.size() == 0) fail("dload0 unexpected dwait pulse");
        else check("dload0", dload[0], exp_d0.pop_front());
      end
      if (!dwait[1] && dREN[1]) begin
        if (exp_d1.size() == 0) fail("dload1 unexpected dwait pulse");
        else check("dload1", dload[1], exp_d1.pop_front());
      end
      if (!iwait[0]) begin
        if (exp_i0.size() == 0) fail("iload0 unexpected iwait pulse");
        else check("iload0", iload[0], exp_i0.pop_front());
      end
      if (!iwait[1]) begin
        if (exp_i1.size() == 0) fail("iload1 unexpected iwait pulse");
        else check("iload1", iload[1], exp_i1.pop_front());
      end
      if (ramstate == 2'd2 && ramREN) begin
        if (exp_r.size() == 0) fail("ram read unexpected");
        else check("ram_read_addr", ramaddr, exp_r.pop_front());
      end
      if (ramstate == 2'd2 && ramWEN) begin
        if (exp_w.size() == 0) fail("ram write unexpected");
        else begin
          wr_t w;
          w = exp_w.pop_front();
          check("ram_write_addr", ramaddr, w.addr);
          check("ram_write_data", ramstore, w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dpulse(input logic c);
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge CLK);
      if (!dwait[c]) return;
    end
    fail($sformatf("timeout waiting dwait[%0d]", c));
  endtask

  task automatic wait_ipulse(input logic c);
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge CLK);
      if (!iwait[c]) return;
    end
    fail($sformatf("timeout waiting iwait[%0d]", c));
  endtask

  task automatic wait_ccwait(input logic c);
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge CLK);
      if (ccwait[c]) return;
    end
    fail($sformatf("timeout waiting ccwait[%0d]", c));
  endtask

  // Count cycles with ccwait[c] high until the first RAM read strobe.
  task automatic count_snoop(input logic c, output int cnt, output logic ccw_at_ren);
    cnt = 0;
    ccw_at_ren = 1'b1;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge CLK);
      if (ramREN) begin
        ccw_at_ren = ccwait[c];
        return;
      end
      if (ccwait[c]) cnt++;
    end
    fail("timeout waiting first ramREN");
  endtask

  task automatic push_d(input logic c, input logic [31:0] v);
    if (c) exp_d1.push_back(v);
    else   exp_d0.push_back(v);
  endtask

  // Two-word dcache read by core c; expected data is queued at issue.
  task automatic core_read(input logic c, input logic [31:0] a, input logic excl,
                           input logic [31:0] d0, input logic [31:0] d1);
    push_d(c, d0);
    push_d(c, d1);
    dREN[c] = 1'b1; ccwrite[c] = excl; daddr[c] = a;
    wait_dpulse(c);
    tick();
    daddr[c] = a + 32'd4;
    wait_dpulse(c);
    tick();
    dREN[c] = 1'b0; ccwrite[c] = 1'b0;
  endtask

  // Snooped core supplying both words after ccwait has been seen.
  task automatic core_supply(input logic c, input logic modified,
                             input logic [31:0] d0, input logic [31:0] d1);
    tick();
    dWEN[c] = 1'b1; cctrans[c] = modified; dstore[c] = d0;
    wait_dpulse(c);
    tick();
    dstore[c] = d1;
    wait_dpulse(c);
    tick();
    dWEN[c] = 1'b0; cctrans[c] = 1'b0;
  endtask

  task automatic core_wb(input logic c, input logic [31:0] a,
                         input logic [31:0] d0, input logic [31:0] d1);
    exp_w.push_back('{addr: a, data: d0});
    exp_w.push_back('{addr: a + 32'd4, data: d1});
    dWEN[c] = 1'b1; dREN[c] = 1'b0; daddr[c] = a; dstore[c] = d0;
    wait_dpulse(c);
    tick();
    daddr[c] = a + 32'd4; dstore[c] = d1;
    wait_dpulse(c);
    tick();
    dWEN[c] = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic ccw;
    int   wr_before;

    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) tick();

    // Reset state, sampled while RST is still asserted.
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ccwait", 32'(ccwait), 32'h0);
    check("rst_ccinv", 32'(ccinv), 32'h0);
    check("rst_ramREN", 32'(ramREN), 32'h0);
    check("rst_ramWEN", 32'(ramWEN), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_dload0", dload[0], 32'h0);
    check("rst_iload0", iload[0], 32'h0);
    tick();
    RST = 1'b0;
    tick();

    // Instruction fetch from 0x40.
    exp_r.push_back(32'h40);
    exp_i0.push_back(32'h8C01_0000);
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    wait_ipulse(1'b0);
    tick();
    iREN[0] = 1'b0;
    repeat (3) tick();

    // Both cores read from reset: core1 first, core0 next; 3 snoop cycles
    // because the idle peer's cctrans=0 is only honoured from the third cycle.
    do_reset();
    exp_r.push_back(32'h400); exp_r.push_back(32'h404);
    exp_r.push_back(32'h300); exp_r.push_back(32'h304);
    fork
      core_read(1'b0, 32'h300, 1'b0, 32'h3000_0001, 32'h3000_0002);
      core_read(1'b1, 32'h400, 1'b0, 32'h4000_0001, 32'h4000_0002);
      begin
        count_snoop(1'b0, cnt, ccw);
        check("t2_snoop_cycles", 32'(cnt), 32'd3);
      end
    join
    repeat (3) tick();

    // Read-exclusive served by modified peer; data written through to RAM.
    exp_w.push_back('{addr: 32'h100, data: 32'h0000_AAAA});
    exp_w.push_back('{addr: 32'h104, data: 32'h0000_BBBB});
    fork
      core_read(1'b0, 32'h100, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB);
      begin
        wait_ccwait(1'b1);
        check("t3_ccinv1", 32'(ccinv[1]), 32'h1);
        check("t3_snoopaddr1", ccsnoopaddr[1], 32'h100);
        core_supply(1'b1, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB);
      end
    join
    repeat (3) tick();

    // Peer drops cctrans after 3 snoop cycles with no dWEN: RAM read.
    exp_r.push_back(32'h200); exp_r.push_back(32'h204);
    cctrans[1] = 1'b1;
    fork
      core_read(1'b0, 32'h200, 1'b0, 32'h1111_2222, 32'h3333_4444);
      begin
        wait_ccwait(1'b1);
        check("t4_ccinv1_low", 32'(ccinv[1]), 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        cctrans[1] = 1'b0;
      end
      begin
        count_snoop(1'b1, cnt, ccw);
        check("t4_ccwait_low_at_ren", 32'(ccw), 32'h0);
        check("t4_snoop_cycles", 32'(cnt), 32'd4);
      end
    join
    repeat (3) tick();

    // Peer never answers: watchdog falls back to RAM after SNOOP_TO cycles.
    exp_r.push_back(32'h500); exp_r.push_back(32'h504);
    cctrans[1] = 1'b1;
    fork
      core_read(1'b0, 32'h500, 1'b0, 32'h5000_0001, 32'h5000_0002);
      begin
        count_snoop(1'b1, cnt, ccw);
        check("t5_ccwait_low_at_ren", 32'(ccw), 32'h0);
        check("t5_snoop_cycles", 32'(cnt), 32'(SNOOP_TO));
      end
    join
    cctrans[1] = 1'b0;
    repeat (3) tick();

    // Writeback outranks a simultaneous instruction fetch.
    exp_r.push_back(32'h40);
    exp_i0.push_back(32'h8C01_0000);
    wr_before = ram_wr_count;
    fork
      core_wb(1'b1, 32'h600, 32'hDEAD_0001, 32'hDEAD_0002);
      begin
        iREN[0] = 1'b1; iaddr[0] = 32'h40;
        wait_ipulse(1'b0);
        tick();
        iREN[0] = 1'b0;
      end
      begin
        count_snoop(1'b0, cnt, ccw);
        check("t7_writes_before_ifetch", 32'(ram_wr_count - wr_before), 32'd2);
      end
    join
    repeat (3) tick();

    // Reset during C2C word 0 aborts the transfer.
    dREN[0] = 1'b1; daddr[0] = 32'h700; ccwrite[0] = 1'b0;
    wait_ccwait(1'b1);
    tick();
    dWEN[1] = 1'b1; cctrans[1] = 1'b1; dstore[1] = 32'h0000_0077;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge CLK);
      if (ramWEN) break;
    end
    check("t6_in_c2c_ramWEN", 32'(ramWEN), 32'h1);
    tick();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("t6_rst_iwait", 32'(iwait), 32'h3);
    check("t6_rst_dwait", 32'(dwait), 32'h3);
    check("t6_rst_ccwait", 32'(ccwait), 32'h0);
    check("t6_rst_ramWEN", 32'(ramWEN), 32'h0);
    check("t6_rst_ramREN", 32'(ramREN), 32'h0);
    dREN = '0; dWEN = '0; cctrans = '0;
    tick();
    RST = 1'b0;
    repeat (4) tick();

    check("end_exp_d0_empty", 32'(exp_d0.size()), 32'd0);
    check("end_exp_d1_empty", 32'(exp_d1.size()), 32'd0);
    check("end_exp_i0_empty", 32'(exp_i0.size()), 32'd0);
    check("end_exp_i1_empty", 32'(exp_i1.size()), 32'd0);
    check("end_exp_r_empty", 32'(exp_r.size()), 32'd0);
    check("end_exp_w_empty", 32'(exp_w.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
